// File: rtl/dif_ctrl_pkg.sv
// Shared types and timing helpers for the radix-2 SDF DIF FFT sequencer.
// Delays and latency are in advances (pipeline steps), not clock cycles.
package dif_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    localparam int VW = 16;

    // Sum over earlier stages of their feedback delay plus multiplier register depth
    function automatic int stage_delay(input int s, input int n, input int tm);
        int d;
        d = 0;
        for (int t = 0; t < VW; t++)
            if (t < s && t < n) d += (1 << (n - 1 - t)) + tm;
        return d;
    endfunction

    function automatic int fft_latency(input int n, input int tm);
        return (1 << n) - 1 + n * tm;
    endfunction

    function automatic logic [VW-1:0] bitrev(input logic [VW-1:0] v, input int n);
        logic [VW-1:0] r;
        logic [VW-1:0] x;
        r = '0;
        x = v;
        for (int i = 0; i < VW; i++) begin
            if (i < n) begin
                r = {r[VW-2:0], x[0]};
                x = x >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dif_stage_seq.sv
// Per-stage sequence counter: starts counting once the global advance count
// reaches this stage's delay, and emits the stage's commutator switch bit.
module dif_stage_seq
    import dif_ctrl_pkg::*;
#(
    parameter int MAX_LOG2N = 6,
    parameter int TM_DELAY  = 1,
    parameter int S         = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   adv,
    input  logic                   clr,
    input  logic [3:0]             n,
    input  logic [MAX_LOG2N+3:0]   k,
    output logic                   sw
);

    localparam int KW = MAX_LOG2N + 4;
    localparam int MW = MAX_LOG2N;

    logic [MW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] sh;
    logic          sw_q, sw_d;
    logic [KW-1:0] d_s;
    logic [MW-1:0] mask;
    logic          used;

    assign d_s  = KW'(stage_delay(S, int'(n), TM_DELAY));
    assign mask = MW'((1 << n) - 1);
    assign used = (int'(n) > S);

    always_comb begin
        cnt_d = cnt_q;
        sw_d  = sw_q;
        sh    = '0;
        if (!used) begin
            sw_d = 1'b0;
        end else if (adv && (k >= d_s)) begin
            sh    = cnt_q >> (int'(n) - 1 - S);
            sw_d  = sh[0];
            cnt_d = (cnt_q + 1'b1) & mask;
        end
        if (clr) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sw_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sw_q  <= sw_d;
        end
    end

    assign sw = sw_q;

endmodule

// File: rtl/dif_fft_seq_ctrl.sv
// Sequencer for a run-time-length SDF radix-2 DIF FFT: stall/flush FSM,
// per-stage switch generation and bit-reversed output tagging.
module dif_fft_seq_ctrl
    import dif_ctrl_pkg::*;
#(
    parameter int MAX_LOG2N = 6,
    parameter int TM_DELAY  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           cfg_log2n,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 flush,
    output logic                 halt_ctrl,
    output logic [MAX_LOG2N-1:0] sw_ctrl,
    output logic                 dout_valid,
    output logic                 dout_sof,
    output logic                 dout_eof,
    output logic [MAX_LOG2N-1:0] dout_idx,
    output logic                 busy
);

    localparam int KW = MAX_LOG2N + 4;
    localparam int MW = MAX_LOG2N;

    state_t        state_q, state_d;
    logic [3:0]    n_q, n_d, n_clamp, n_w;
    logic [KW-1:0] k_q, k_d, fcnt_q, fcnt_d, lat;
    logic [MW-1:0] pos_q, pos_d, jout_q, jout_d, idx_q, idx_d, mask;
    logic          halt_q, halt_d, valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
    logic          adv, emit, last_flush;

    always_comb begin
        n_clamp = cfg_log2n;
        if (cfg_log2n == 4'd0)                 n_clamp = 4'd1;
        else if (cfg_log2n > 4'(MAX_LOG2N))    n_clamp = 4'(MAX_LOG2N);
    end

    // In IDLE the incoming configuration governs the very first advance
    assign n_w        = (state_q == IDLE) ? n_clamp : n_q;
    assign mask       = MW'((1 << n_w) - 1);
    assign lat        = KW'(fft_latency(int'(n_w), TM_DELAY));
    assign din_ready  = (state_q != FLUSH);
    assign adv        = (state_q == FLUSH) || (din_valid && din_ready);
    assign emit       = adv && (k_q >= lat);
    assign last_flush = (state_q == FLUSH) && (fcnt_q == KW'(1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        pos_d   = pos_q;
        jout_d  = jout_q;
        fcnt_d  = fcnt_q;
        idx_d   = idx_q;
        halt_d  = ~adv;
        valid_d = emit;
        sof_d   = emit && (jout_q == '0);
        eof_d   = emit && (jout_q == mask);
        if (adv) begin
            pos_d = (pos_q + 1'b1) & mask;
            if (k_q < lat) k_d = k_q + 1'b1;
        end
        if (emit) begin
            idx_d  = MW'(bitrev(VW'(jout_q), int'(n_w)));
            jout_d = (jout_q + 1'b1) & mask;
        end
        case (state_q)
            IDLE: begin
                if (adv) begin
                    state_d = FILL;
                    n_d     = n_clamp;
                end
            end
            FILL, RUN: begin
                // Pad the open input frame to its end, then drain the full pipe latency
                if (flush) begin
                    state_d = FLUSH;
                    fcnt_d  = KW'((MW'(0) - pos_d) & mask) + lat;
                end else if (state_q == FILL && emit) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q - 1'b1;
                if (last_flush) begin
                    state_d = IDLE;
                    k_d     = '0;
                    pos_d   = '0;
                    jout_d  = '0;
                    fcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= 4'd1;
            k_q     <= '0;
            pos_q   <= '0;
            jout_q  <= '0;
            fcnt_q  <= '0;
            idx_q   <= '0;
            halt_q  <= 1'b1;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            pos_q   <= pos_d;
            jout_q  <= jout_d;
            fcnt_q  <= fcnt_d;
            idx_q   <= idx_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    for (genvar s = 0; s < MAX_LOG2N; s++) begin : g_stage
        dif_stage_seq #(
            .MAX_LOG2N (MAX_LOG2N),
            .TM_DELAY  (TM_DELAY),
            .S         (s)
        ) u_seq (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .clr   (last_flush),
            .n     (n_w),
            .k     (k_q),
            .sw    (sw_ctrl[s])
        );
    end

    assign halt_ctrl  = halt_q;
    assign dout_valid = valid_q;
    assign dout_sof   = sof_q;
    assign dout_eof   = eof_q;
    assign dout_idx   = idx_q;
    assign busy       = (state_q != IDLE);

endmodule
